// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: definitions shared by the interrupt controller and its users.
//   - register select encoding for the 2-bit addr bus
//   - CTRL and VECT bit positions
//   - default number of interrupt source lines
package irq_ctrl_pkg;

  localparam int IRQ_CH_DEFAULT = 8;
  localparam int DATA_W         = 32;
  localparam int ID_W           = 3;

  // CTRL layout: GIE on bit 0, per-line EDGE select starting at bit 8
  localparam int CTRL_GIE_BIT   = 0;
  localparam int CTRL_EDGE_LSB  = 8;

  // VECT layout: winning index on bits [2:0], valid flag on bit 8
  localparam int VECT_VALID_BIT = 8;

  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_MASK = 2'd1,
    REG_PEND = 2'd2,
    REG_VECT = 2'd3
  } reg_sel_e;

endpackage : irq_ctrl_pkg

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-index-wins priority encoder.
// Ports:
//   req   - request vector, one bit per interrupt line
//   id    - index of the lowest set request bit (0 when none set)
//   valid - 1 when any request bit is set
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N = IRQ_CH_DEFAULT
) (
  input  logic [N-1:0]    req,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  logic found_s;

  // Scan upward; the first set bit claims the id and blocks higher ones
  always_comb begin
    id      = 3'd0;
    found_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !found_s) begin
        id      = 3'(i);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    valid = found_s;
  end

endmodule : irq_prio_enc

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller with per-line level/edge
// triggering, mask, write-1-to-clear pending and a priority vector.
// Ports:
//   clk, reset       - clock and asynchronous active-high reset
//   cs_, as_, rw     - bus chip select / address strobe (active low), 1=read
//   addr, wr_data    - register select (CTRL/MASK/PEND/VECT) and write data
//   rd_data, rdy_    - registered read data and ready (active low)
//   irq_in           - interrupt source lines, active high, clk domain
//   cpu_irq, irq_id  - registered request to the CPU and winning index
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int IRQ_CH = IRQ_CH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rdy_,
  input  logic [IRQ_CH-1:0] irq_in,
  output logic              cpu_irq,
  output logic [ID_W-1:0]   irq_id
);

  logic              access_s;
  logic              wr_s;
  logic              rd_s;
  logic              gie_r;
  logic [IRQ_CH-1:0] edge_r;
  logic [IRQ_CH-1:0] mask_r;
  logic [IRQ_CH-1:0] pend_r;
  logic [IRQ_CH-1:0] prev_r;
  logic [IRQ_CH-1:0] set_s;
  logic [IRQ_CH-1:0] clr_s;
  logic [IRQ_CH-1:0] req_s;
  logic [ID_W-1:0]   win_id_s;
  logic              win_valid_s;
  logic [DATA_W-1:0] rd_mux_s;
  logic              wr_data_unused_s;

  // Bits of wr_data beyond the implemented fields are deliberately dropped
  assign wr_data_unused_s = ^wr_data;

  // Bus access decode
  always_comb begin
    access_s = ~cs_ & ~as_;
    wr_s     = access_s & ~rw;
    rd_s     = access_s & rw;
  end

  // Pending set sources: rising edge on edge lines, high level otherwise
  always_comb begin
    set_s = (edge_r & irq_in & ~prev_r) | (~edge_r & irq_in);
  end

  // Write-1-to-clear vector for PEND
  always_comb begin
    if (wr_s && (reg_sel_e'(addr) == REG_PEND)) begin
      clr_s = wr_data[IRQ_CH-1:0];
    end else begin
      clr_s = {IRQ_CH{1'b0}};
    end
  end

  assign req_s = pend_r & mask_r;

  irq_prio_enc #(
    .N (IRQ_CH)
  ) u_prio_enc (
    .req   (req_s),
    .id    (win_id_s),
    .valid (win_valid_s)
  );

  // Read mux; unimplemented bits read as zero
  always_comb begin
    rd_mux_s = 32'd0;
    case (reg_sel_e'(addr))
      REG_CTRL: begin
        rd_mux_s[CTRL_GIE_BIT]            = gie_r;
        rd_mux_s[CTRL_EDGE_LSB +: IRQ_CH] = edge_r;
      end
      REG_MASK: rd_mux_s[IRQ_CH-1:0] = mask_r;
      REG_PEND: rd_mux_s[IRQ_CH-1:0] = pend_r;
      REG_VECT: begin
        rd_mux_s[ID_W-1:0]       = irq_id;
        rd_mux_s[VECT_VALID_BIT] = win_valid_s;
      end
      default:  rd_mux_s = 32'd0;
    endcase
  end

  // CTRL and MASK registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gie_r  <= 1'b0;
      edge_r <= {IRQ_CH{1'b0}};
      mask_r <= {IRQ_CH{1'b0}};
    end else if (wr_s) begin
      case (reg_sel_e'(addr))
        REG_CTRL: begin
          gie_r  <= wr_data[CTRL_GIE_BIT];
          edge_r <= wr_data[CTRL_EDGE_LSB +: IRQ_CH];
        end
        REG_MASK: mask_r <= wr_data[IRQ_CH-1:0];
        default:  mask_r <= mask_r;
      endcase
    end
  end

  // Pending latch and edge history; a set in the same cycle beats a clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_r <= {IRQ_CH{1'b0}};
      prev_r <= {IRQ_CH{1'b0}};
    end else begin
      pend_r <= (pend_r & ~clr_s) | set_s;
      prev_r <= irq_in;
    end
  end

  // Registered bus response: ready after every access, data only after reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_    <= 1'b1;
      rd_data <= 32'd0;
    end else begin
      rdy_    <= ~access_s;
      rd_data <= rd_s ? rd_mux_s : 32'd0;
    end
  end

  // Registered interrupt outputs; irq_id holds its value when nothing wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_irq <= 1'b0;
      irq_id  <= 3'd0;
    end else begin
      cpu_irq <= gie_r & win_valid_s;
      if (win_valid_s) begin
        irq_id <= win_id_s;
      end
    end
  end

endmodule : irq_ctrl

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl (IRQ_CH = 8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;
  logic [7:0]  irq_in;
  logic        cpu_irq;
  logic [2:0]  irq_id;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_PEND = 2'd2;
  localparam logic [1:0] A_VECT = 2'd3;

  irq_ctrl #(.IRQ_CH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs_     (cs_),
    .as_     (as_),
    .rw      (rw),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .rdy_    (rdy_),
    .irq_in  (irq_in),
    .cpu_irq (cpu_irq),
    .irq_id  (irq_id)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = a; wr_data = d;
    @(negedge clk);
    cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; wr_data = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = a;
    @(negedge clk);
    d = rd_data;
    cs_ = 1'b1; as_ = 1'b1; rw = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1;
    addr = 2'd0; wr_data = 32'd0; irq_in = 8'h00;
    repeat (2) @(negedge clk);
    n_checks++; if (rdy_ !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", rdy_); end
    n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    n_checks++; if (cpu_irq !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_irq: got %b want 0", cpu_irq); end
    n_checks++; if (irq_id !== 3'd0) begin n_fail++; $display("FAIL reset_irq_id: got %0d want 0", irq_id); end
    reset = 1'b0;
    bus_read(A_CTRL, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", d); end
    bus_read(A_MASK, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_mask: got %h want 0", d); end
    bus_read(A_PEND, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_pend: got %h want 0", d); end
    bus_read(A_VECT, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_vect: got %h want 0", d); end
  endtask

  task automatic test_reg_access();
    logic [31:0] d;
    bus_write(A_CTRL, 32'hFFFF_FFFF);
    bus_read(A_CTRL, d);
    n_checks++; if (d !== 32'h0000_FF01) begin n_fail++; $display("FAIL ctrl_unused_bits: got %h want 0000ff01", d); end
    bus_write(A_MASK, 32'hFFFF_FFFF);
    bus_read(A_MASK, d);
    n_checks++; if (d !== 32'h0000_00FF) begin n_fail++; $display("FAIL mask_unused_bits: got %h want 000000ff", d); end
    bus_write(A_VECT, 32'hFFFF_FFFF);
    bus_read(A_VECT, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL vect_write_ignored: got %h want 0", d); end
    bus_read(A_PEND, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL pend_unchanged_by_cfg: got %h want 0", d); end
    bus_write(A_CTRL, 32'd0);
    bus_write(A_MASK, 32'd0);
  endtask

  task automatic test_level();
    logic [31:0] d;
    bus_write(A_MASK, 32'h0000_0001);
    bus_write(A_CTRL, 32'h0000_0001);
    @(negedge clk); irq_in = 8'h01;
    @(negedge clk); irq_in = 8'h00;
    n_checks++; if (cpu_irq !== 1'b0) begin n_fail++; $display("FAIL level_irq_latency: got %b want 0", cpu_irq); end
    @(negedge clk);
    n_checks++; if (cpu_irq !== 1'b1) begin n_fail++; $display("FAIL level_cpu_irq: got %b want 1", cpu_irq); end
    bus_read(A_PEND, d);
    n_checks++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL level_pend: got %h want 00000001", d); end
    bus_read(A_VECT, d);
    n_checks++; if (d !== 32'h0000_0100) begin n_fail++; $display("FAIL level_vect: got %h want 00000100", d); end
    bus_write(A_PEND, 32'h0000_0001);
    @(negedge clk);
    n_checks++; if (cpu_irq !== 1'b0) begin n_fail++; $display("FAIL level_clear_irq: got %b want 0", cpu_irq); end
    bus_read(A_PEND, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL level_clear_pend: got %h want 0", d); end
  endtask

  task automatic test_set_beats_clear();
    logic [31:0] d;
    @(negedge clk); irq_in = 8'h01;
    repeat (2) @(negedge clk);
    n_checks++; if (cpu_irq !== 1'b1) begin n_fail++; $display("FAIL held_cpu_irq: got %b want 1", cpu_irq); end
    bus_write(A_PEND, 32'h0000_0001);
    @(negedge clk);
    n_checks++; if (cpu_irq !== 1'b1) begin n_fail++; $display("FAIL set_prio_irq: got %b want 1", cpu_irq); end
    bus_read(A_PEND, d);
    n_checks++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL set_prio_pend: got %h want 00000001", d); end
    @(negedge clk); irq_in = 8'h00;
    bus_write(A_PEND, 32'h0000_0001);
    @(negedge clk);
    n_checks++; if (cpu_irq !== 1'b0) begin n_fail++; $display("FAIL set_prio_release: got %b want 0", cpu_irq); end
  endtask

  task automatic test_edge();
    logic [31:0] d;
    bus_write(A_CTRL, 32'h0000_0801);
    bus_write(A_MASK, 32'h0000_0008);
    @(negedge clk); irq_in = 8'h08;
    repeat (3) @(negedge clk);
    n_checks++; if (irq_id !== 3'd3) begin n_fail++; $display("FAIL edge_irq_id: got %0d want 3", irq_id); end
    bus_read(A_PEND, d);
    n_checks++; if (d !== 32'h0000_0008) begin n_fail++; $display("FAIL edge_pend_set: got %h want 00000008", d); end
    bus_write(A_PEND, 32'h0000_0008);
    bus_read(A_PEND, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL edge_pend_once: got %h want 0", d); end
    n_checks++; if (cpu_irq !== 1'b0) begin n_fail++; $display("FAIL edge_cpu_irq_clear: got %b want 0", cpu_irq); end
    @(negedge clk); irq_in = 8'h00;
    bus_write(A_CTRL, 32'h0000_0001);
  endtask

  task automatic test_priority();
    logic [31:0] d;
    bus_write(A_MASK, 32'h0000_00FF);
    @(negedge clk); irq_in = 8'h24;
    @(negedge clk); irq_in = 8'h00;
    @(negedge clk);
    n_checks++; if (irq_id !== 3'd2) begin n_fail++; $display("FAIL prio_id_2: got %0d want 2", irq_id); end
    n_checks++; if (cpu_irq !== 1'b1) begin n_fail++; $display("FAIL prio_cpu_irq: got %b want 1", cpu_irq); end
    bus_read(A_VECT, d);
    n_checks++; if (d !== 32'h0000_0102) begin n_fail++; $display("FAIL prio_vect: got %h want 00000102", d); end
    bus_write(A_MASK, 32'h0000_00FB);
    @(negedge clk);
    n_checks++; if (irq_id !== 3'd5) begin n_fail++; $display("FAIL prio_id_5: got %0d want 5", irq_id); end
    bus_write(A_CTRL, 32'd0);
    @(negedge clk);
    n_checks++; if (cpu_irq !== 1'b0) begin n_fail++; $display("FAIL prio_gie_off: got %b want 0", cpu_irq); end
    bus_read(A_PEND, d);
    n_checks++; if (d !== 32'h0000_0024) begin n_fail++; $display("FAIL prio_pend_kept: got %h want 00000024", d); end
    bus_write(A_MASK, 32'd0);
    @(negedge clk);
    bus_read(A_VECT, d);
    n_checks++; if (d !== 32'h0000_0005) begin n_fail++; $display("FAIL prio_id_hold: got %h want 00000005", d); end
    bus_write(A_PEND, 32'h0000_0024);
  endtask

  task automatic test_rdy_and_reset();
    logic [31:0] d;
    bus_write(A_MASK, 32'h0000_005A);
    bus_write(A_CTRL, 32'h0000_0001);
    @(negedge clk);
    n_checks++; if (rdy_ !== 1'b1) begin n_fail++; $display("FAIL rdy_idle: got %b want 1", rdy_); end
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = A_MASK;
    @(negedge clk);
    cs_ = 1'b1; as_ = 1'b1;
    n_checks++; if (rdy_ !== 1'b0) begin n_fail++; $display("FAIL rdy_after_read: got %b want 0", rdy_); end
    n_checks++; if (rd_data !== 32'h0000_005A) begin n_fail++; $display("FAIL rd_data_mask: got %h want 0000005a", rd_data); end
    @(negedge clk);
    n_checks++; if (rdy_ !== 1'b1) begin n_fail++; $display("FAIL rdy_release: got %b want 1", rdy_); end
    n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL rd_data_zero: got %h want 0", rd_data); end
    // put a live interrupt on line 1 before hitting reset mid-write
    irq_in = 8'h02;
    @(negedge clk); irq_in = 8'h00;
    @(negedge clk);
    n_checks++; if (irq_id !== 3'd1) begin n_fail++; $display("FAIL pre_reset_id: got %0d want 1", irq_id); end
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = A_MASK; wr_data = 32'h0000_00FF;
    reset = 1'b1;
    #1;
    n_checks++; if (rdy_ !== 1'b1) begin n_fail++; $display("FAIL midwr_rdy: got %b want 1", rdy_); end
    n_checks++; if (cpu_irq !== 1'b0) begin n_fail++; $display("FAIL midwr_cpu_irq: got %b want 0", cpu_irq); end
    n_checks++; if (irq_id !== 3'd0) begin n_fail++; $display("FAIL midwr_irq_id: got %0d want 0", irq_id); end
    @(negedge clk);
    cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; wr_data = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    bus_read(A_MASK, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL midwr_mask: got %h want 0", d); end
    bus_read(A_CTRL, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL midwr_ctrl: got %h want 0", d); end
    bus_read(A_PEND, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL midwr_pend: got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_reg_access();
    test_level();
    test_set_beats_clear();
    test_edge();
    test_priority();
    test_rdy_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_irq_ctrl

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter IRQ_CH, default 8, number of interrupt source lines (1..8).
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port cs_  in  1  chip select, active low.
REQ-005 SHALL have port as_  in  1  address strobe, active low.
REQ-006 SHALL have port rw  in  1  1 = read, 0 = write.
REQ-007 SHALL have port addr  in  2  register select: 0 CTRL, 1 MASK, 2 PEND, 3 VECT.
REQ-008 SHALL have port wr_data  in  32  write data.
REQ-009 SHALL have port rd_data  out  32  registered read data.
REQ-010 SHALL have port rdy_  out  1  registered ready, active low.
REQ-011 SHALL have port irq_in  in  IRQ_CH  source lines (timer irq on bit 0), active high, same clock domain.
REQ-012 SHALL have port cpu_irq  out  1  registered interrupt request to the CPU.
REQ-013 SHALL have port irq_id  out  3  registered index of the winning source.

Function
REQ-014 SHALL define an access as cs_=0 and as_=0 in a cycle; rdy_ SHALL be 0 in the cycle after every access and 1 otherwise (single-cycle latency, no wait states).
REQ-015 SHALL load rd_data one cycle after a read access with the addressed register, zero-extended; rd_data SHALL be 0 in every other cycle.
REQ-016 SHALL implement CTRL: bit0 GIE (global enable, RW); bits[8+IRQ_CH-1:8] EDGE (per line, 1 = rising-edge trigger, 0 = level trigger, RW).
REQ-017 SHALL implement MASK: bits[IRQ_CH-1:0] per-line enable (RW).
REQ-018 SHALL implement PEND: bits[IRQ_CH-1:0] latched pending; read returns PEND; write clears every bit written as 1 (write-1-to-clear), bits written 0 unchanged.
REQ-019 SHALL implement VECT (read-only): bits[2:0] = irq_id, bit8 = valid (any masked pending bit); reading has no side effect; writes ignored.
REQ-020 SHALL, for a level line, set its PEND bit in every cycle irq_in is 1, independent of MASK.
REQ-021 SHALL, for an edge line, set its PEND bit in the cycle after a registered previous sample of 0 and a current sample of 1.
REQ-022 SHALL give set priority over write-1-to-clear when both target the same bit in the same cycle.
REQ-023 SHALL select the winner as the lowest index with PEND&MASK set; irq_id SHALL hold its last value when none is set.
REQ-024 SHALL drive cpu_irq = GIE AND (|(PEND&MASK)), registered, i.e. one cycle after PEND/MASK/GIE update.
REQ-025 SHALL make writes to CTRL/MASK/PEND visible in the register from the next cycle; MASK/GIE changes never alter PEND.
REQ-026 SHALL treat IRQ_CH < 8 by reading unused bits as 0 and ignoring writes to them.

Reset
REQ-027 SHALL, while reset=1, force rd_data=0, rdy_=1, GIE=0, EDGE=0, MASK=0, PEND=0, edge history=0, cpu_irq=0, irq_id=0.
REQ-028 SHALL abort any access in progress on reset assertion; no write takes effect in the reset cycle; first access accepted on the first rising edge after release.

Structure
REQ-029 SHALL place register addresses, CTRL bit positions, VECT valid bit position and IRQ_CH default in shared header irq_ctrl.h alongside existing global definitions.
REQ-030 SHALL contain one sub-module, irq_prio_enc: combinational IRQ_CH-to-3-bit lowest-index priority encoder with valid output.

Verification
REQ-031 SHALL test: MASK=0x01, GIE=1, level irq_in[0] pulses 1 cycle -> PEND=0x01, cpu_irq=1 next cycle, VECT reads 0x100; write PEND=0x01 -> cpu_irq=0.
REQ-032 SHALL test: level irq_in[0] held 1, write PEND=0x01 same cycle as set -> PEND remains 0x01, cpu_irq stays 1.
REQ-033 SHALL test: EDGE bit3=1, MASK=0x08, irq_in[3] held high 10 cycles -> exactly one PEND set; after clear PEND=0 while line still high.
REQ-034 SHALL test: PEND=0x24 set, MASK=0xFF -> irq_id=2; MASK=0xFB -> irq_id=5; GIE=0 -> cpu_irq=0, PEND still 0x24.
REQ-035 SHALL test: any read -> rdy_=0 exactly one cycle later, rd_data=0 the cycle after; reset asserted mid-write to MASK -> MASK=0, rdy_=1, cpu_irq=0.
